// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training slice: pattern width,
// the two reference training patterns and the trainer state encoding.
package perceptron_pkg;
  localparam int PAT_W = 24;

  localparam logic [PAT_W:0] CIRCLE_VAL = {1'b0, 24'h45_45_44};
  localparam logic [PAT_W:0] CROSS_VAL  = {1'b1, 24'h15_11_51};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_EVAL,
    ST_DONE
  } trainer_state_e;
endpackage

// File: rtl/perceptron_if.sv
// Sample interface between the trainer (initiator) and the perceptron (responder).
// Handshake: p_in/p_en are held stable until the first rising edge with p_en && p_ready;
// p_out is valid on that same edge and the sample counts as consumed there.
interface perceptron_if;
  logic [perceptron_pkg::PAT_W:0] p_in;
  logic                           p_en;
  logic                           p_ready;
  logic [1:0]                     p_out;

  modport master (output p_in, output p_en, input p_ready, input p_out);
  modport slave  (input p_in, input p_en, output p_ready, output p_out);
endinterface

// File: rtl/perceptron_sample_rom.sv
// Combinational training-set ROM: index -> {label, pattern}.
// Even indices hold the circle pattern, odd indices the cross pattern.
module sample_rom
  import perceptron_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx,
  output logic [PAT_W:0]   data
);
  always_comb begin
    data = CIRCLE_VAL;
    if ((idx & IDX_W'(1)) != '0) data = CROSS_VAL;
  end
endmodule

// File: rtl/perceptron_trainer.sv
// Replays the training set into the perceptron epoch by epoch until an epoch
// is error-free, the epoch budget is spent, or the responder stalls.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES  = 4,
  parameter int MAX_EPOCHS = 16,
  parameter int TIMEOUT    = 256,
  localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int EP_W  = $clog2(MAX_EPOCHS + 1),
  localparam int ERR_W = $clog2(N_SAMPLES + 1),
  localparam int WD_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  perceptron_if.master         pif,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic                 timeout,
  output logic [EP_W-1:0]      epoch_cnt,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [1:0]           last_out,
  output trainer_state_e       dbg_state
);
  trainer_state_e   state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rom_addr;
  logic [PAT_W:0]   rom_data;
  logic [WD_W-1:0]  wd;

  assign dbg_state = state;

  // In GAP the ROM already looks up the next sample; elsewhere it presents sample 0.
  always_comb begin
    rom_addr = '0;
    if (state == ST_GAP) rom_addr = idx + 1'b1;
  end

  sample_rom #(.IDX_W(IDX_W)) u_rom (
    .idx  (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pif.p_in  <= '0;
      pif.p_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      timeout   <= 1'b0;
      epoch_cnt <= '0;
      err_cnt   <= '0;
      idx       <= '0;
      wd        <= '0;
      last_out  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            epoch_cnt <= '0;
            err_cnt   <= '0;
            idx       <= '0;
            wd        <= '0;
            done      <= 1'b0;
            converged <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            pif.p_in  <= rom_data;
            pif.p_en  <= 1'b1;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // p_en is always high here, so p_ready alone completes the handshake.
          if (pif.p_ready) begin
            last_out <= pif.p_out;
            if (pif.p_out[1]) err_cnt <= err_cnt + 1'b1;
            pif.p_en <= 1'b0;
            wd       <= '0;
            state    <= ST_GAP;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            pif.p_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= 1'b1;
            converged <= 1'b0;
            state     <= ST_DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_GAP: begin
          if (idx < IDX_W'(N_SAMPLES - 1)) begin
            idx      <= idx + 1'b1;
            pif.p_in <= rom_data;
            pif.p_en <= 1'b1;
            state    <= ST_DRIVE;
          end else begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          epoch_cnt <= epoch_cnt + 1'b1;
          if (err_cnt == '0) begin
            converged <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end else if (epoch_cnt == EP_W'(MAX_EPOCHS - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            err_cnt  <= '0;
            idx      <= '0;
            pif.p_in <= rom_data;
            pif.p_en <= 1'b1;
            state    <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
